// File: rtl/result_frame_sink.sv
// Frame buffer sink for the adaptive-threshold result stream: stores one majority bit per
// pixel, counts accepted writes and replays the frame in raster order over valid/ready.
module result_frame_sink #(
    parameter int unsigned WIDTH_BITS  = 8,
    parameter int unsigned HEIGHT_BITS = 8
) (
    input  logic                             clock,
    input  logic                             not_reset,
    input  logic [HEIGHT_BITS-1:0]           iX,
    input  logic [WIDTH_BITS-1:0]            iY,
    input  logic [2:0]                       iR,
    input  logic [2:0]                       iG,
    input  logic [2:0]                       iB,
    input  logic                             iWren,
    input  logic                             iClearCount,
    input  logic                             iScanStart,
    input  logic                             iScanReady,
    output logic                             oScanValid,
    output logic [HEIGHT_BITS-1:0]           oScanX,
    output logic [WIDTH_BITS-1:0]            oScanY,
    output logic                             oScanPixel,
    output logic                             oScanLast,
    output logic [WIDTH_BITS+HEIGHT_BITS:0]  oWriteCount,
    output logic                             oFrameComplete,
    output logic                             oBusy
);

    localparam int unsigned AddrBits  = WIDTH_BITS + HEIGHT_BITS;
    localparam int unsigned NumPixels = 1 << AddrBits;

    localparam logic [AddrBits:0]   FullCount = {1'b1, {AddrBits{1'b0}}};
    localparam logic [AddrBits:0]   CountOne  = {{AddrBits{1'b0}}, 1'b1};
    localparam logic [AddrBits-1:0] AddrOne   = {{(AddrBits - 1){1'b0}}, 1'b1};
    localparam logic [AddrBits-1:0] LastAddr  = '1;

    typedef enum logic [1:0] {StIdle, StFetch, StPresent} state_e;

    state_e                state_q, state_d;
    logic [AddrBits-1:0]   addr_q, addr_d;
    logic [AddrBits:0]     count_q, count_d;
    logic                  complete_q;
    logic                  pixel_q;
    logic                  wr_bit;
    logic                  frame_q [NumPixels];

    // Only the MSB of each colour channel takes part in the vote.
    logic unused_rgb_lsbs;
    assign unused_rgb_lsbs = ^{iR[1:0], iG[1:0], iB[1:0]};

    assign wr_bit = (iR[2] & iG[2]) | (iR[2] & iB[2]) | (iG[2] & iB[2]);

    // Buffer survives reset so an aborted scan can be replayed.
    always_ff @(posedge clock) begin
        if (iWren) begin
            frame_q[{iX, iY}] <= wr_bit;
        end
    end

    always_comb begin
        count_d = count_q;
        if (iClearCount) begin
            count_d = iWren ? CountOne : '0;
        end else if (iWren && (count_q != FullCount)) begin
            count_d = count_q + CountOne;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (iScanStart) begin
                    addr_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StPresent;
            end
            StPresent: begin
                if (iScanReady) begin
                    if (addr_q == LastAddr) begin
                        state_d = StIdle;
                    end else begin
                        addr_d  = addr_q + AddrOne;
                        state_d = StFetch;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            count_q    <= '0;
            complete_q <= 1'b0;
            pixel_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            complete_q <= (count_d == FullCount);
            // Read uses pre-edge contents, so a same-cycle write is not seen.
            if (state_q == StFetch) begin
                pixel_q <= frame_q[addr_q];
            end
        end
    end

    assign oScanValid     = (state_q == StPresent);
    assign oBusy          = (state_q != StIdle);
    assign oScanX         = addr_q[AddrBits-1:WIDTH_BITS];
    assign oScanY         = addr_q[WIDTH_BITS-1:0];
    assign oScanPixel     = pixel_q;
    assign oScanLast      = oScanValid && (addr_q == LastAddr);
    assign oWriteCount    = count_q;
    assign oFrameComplete = complete_q;

endmodule

// File: tb/tb_result_frame_sink.sv
// Randomised scoreboard bench for result_frame_sink on a reduced 16x32 frame so full scans
// and counter saturation fit in a short run.
module tb_result_frame_sink;

    localparam int unsigned HB   = 4;
    localparam int unsigned WB   = 5;
    localparam int          AB   = HB + WB;
    localparam int          NPIX = 1 << AB;
    localparam int          NCOL = 1 << WB;

    logic          clock = 1'b0;
    logic          not_reset = 1'b1;
    logic [HB-1:0] iX = '0;
    logic [WB-1:0] iY = '0;
    logic [2:0]    iR = '0, iG = '0, iB = '0;
    logic          iWren = 1'b0, iClearCount = 1'b0, iScanStart = 1'b0, iScanReady = 1'b0;
    logic          oScanValid, oScanPixel, oScanLast, oFrameComplete, oBusy;
    logic [HB-1:0] oScanX;
    logic [WB-1:0] oScanY;
    logic [AB:0]   oWriteCount;

    result_frame_sink #(
        .WIDTH_BITS  (WB),
        .HEIGHT_BITS (HB)
    ) dut (
        .clock          (clock),
        .not_reset      (not_reset),
        .iX             (iX),
        .iY             (iY),
        .iR             (iR),
        .iG             (iG),
        .iB             (iB),
        .iWren          (iWren),
        .iClearCount    (iClearCount),
        .iScanStart     (iScanStart),
        .iScanReady     (iScanReady),
        .oScanValid     (oScanValid),
        .oScanX         (oScanX),
        .oScanY         (oScanY),
        .oScanPixel     (oScanPixel),
        .oScanLast      (oScanLast),
        .oWriteCount    (oWriteCount),
        .oFrameComplete (oFrameComplete),
        .oBusy          (oBusy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int pix;
        int last;
    } exp_t;

    exp_t sb[$];
    bit   ref_mem [NPIX];
    int   ref_count = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   stall_pending = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int majority(input int r, input int g, input int b);
        return (((r >> 2) & 1) + ((g >> 2) & 1) + ((b >> 2) & 1)) >= 2 ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_px(input int x, input int y, input int r, input int g, input int b,
                            input bit clr);
        iX = x[HB-1:0];
        iY = y[WB-1:0];
        iR = r[2:0];
        iG = g[2:0];
        iB = b[2:0];
        iWren = 1'b1;
        iClearCount = clr;
        tick();
        iWren = 1'b0;
        iClearCount = 1'b0;
        ref_mem[x * NCOL + y] = (majority(r, g, b) != 0);
        if (clr) ref_count = 1;
        else if (ref_count < NPIX) ref_count = ref_count + 1;
    endtask

    task automatic check_count(input string tag);
        check({tag, "_count"}, int'(oWriteCount), ref_count);
        check({tag, "_complete"}, int'(oFrameComplete), (ref_count == NPIX) ? 1 : 0);
    endtask

    task automatic push_frame();
        for (int i = 0; i < NPIX; i++) begin
            sb.push_back('{i / NCOL, i % NCOL, int'(ref_mem[i]), (i == NPIX - 1) ? 1 : 0});
        end
    endtask

    // Monitor: compares every presented pixel against the head of the scoreboard.
    always @(negedge clock) begin
        if (!not_reset) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) check("valid_held", int'(oScanValid), 1);
            if (oScanValid) begin
                check("scoreboard_nonempty", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    check("scan_x", int'(oScanX), sb[0].x);
                    check("scan_y", int'(oScanY), sb[0].y);
                    check("scan_pixel", int'(oScanPixel), sb[0].pix);
                    check("scan_last", int'(oScanLast), sb[0].last);
                    if (iScanReady) void'(sb.pop_front());
                end
            end
            stall_pending = oScanValid && !iScanReady;
        end
    end

    // mode 0: always ready, 1: random ready and stray starts, 2: 5-cycle stall at (0,2)
    task automatic run_scan(input int mode);
        int cyc;
        push_frame();
        iScanReady = 1'b1;
        iScanStart = 1'b1;
        tick();
        iScanStart = 1'b0;
        check("start_busy", int'(oBusy), 1);
        check("start_no_valid", int'(oScanValid), 0);
        tick();
        check("first_valid", int'(oScanValid), 1);
        if (mode == 2) begin
            cyc = 0;
            while (!(oScanValid && oScanX == 0 && oScanY == 2) && cyc < 20) begin
                tick();
                cyc++;
            end
            check("reach_0_2", int'(oScanValid && oScanX == 0 && oScanY == 2), 1);
            iScanReady = 1'b0;
            repeat (5) tick();
            iScanReady = 1'b1;
            tick();
            check("gap_after_accept", int'(oScanValid), 0);
            tick();
            check("next_valid", int'(oScanValid), 1);
            check("next_y", int'(oScanY), 3);
        end
        cyc = 0;
        while (oBusy && cyc < 8 * NPIX) begin
            if (mode == 1) begin
                iScanReady = ($urandom_range(0, 1) != 0);
                iScanStart = ($urandom_range(0, 3) == 0);
            end
            tick();
            cyc++;
        end
        iScanStart = 1'b0;
        iScanReady = 1'b1;
        check("scan_finished", int'(oBusy), 0);
        check("idle_no_valid", int'(oScanValid), 0);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        #2;
        not_reset = 1'b0;
        #10;
        check("rst_valid", int'(oScanValid), 0);
        check("rst_busy", int'(oBusy), 0);
        check("rst_x", int'(oScanX), 0);
        check("rst_y", int'(oScanY), 0);
        check("rst_pixel", int'(oScanPixel), 0);
        check("rst_last", int'(oScanLast), 0);
        check_count("rst");
        tick();
        not_reset = 1'b1;
        tick();

        // Fill the whole frame with random colours; count reaches saturation.
        for (int a = 0; a < NPIX; a++) begin
            write_px(a / NCOL, a % NCOL, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), 1'b0);
            if (a == NPIX - 2) check_count("pre_full");
        end
        check_count("full");

        write_px(0, 0, 7, 7, 7, 1'b0);
        check_count("saturated");
        write_px(0, 1, 0, 0, 0, 1'b0);
        write_px((1 << HB) - 1, NCOL - 1, 7, 7, 7, 1'b0);
        write_px(0, 2, 4, 4, 0, 1'b0);
        write_px(0, 3, 4, 0, 0, 1'b0);
        write_px(0, 4, 3, 3, 3, 1'b0);
        check_count("still_saturated");

        write_px(1, 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1'b1);
        check_count("clear_with_write");
        iClearCount = 1'b1;
        tick();
        iClearCount = 1'b0;
        ref_count = 0;
        check_count("clear_only");

        run_scan(0);
        run_scan(2);

        for (int k = 0; k < 40; k++) begin
            write_px($urandom_range(0, (1 << HB) - 1), $urandom_range(0, NCOL - 1),
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1'b0);
        end
        check_count("after_rewrites");
        run_scan(1);

        // Abort at the 100th presented pixel, then replay from the top.
        push_frame();
        iScanReady = 1'b1;
        iScanStart = 1'b1;
        tick();
        iScanStart = 1'b0;
        cyc = 0;
        while (!(oScanValid && oScanX == 3 && oScanY == 3) && cyc < 400) begin
            tick();
            cyc++;
        end
        check("reach_pixel_99", int'(oScanValid && oScanX == 3 && oScanY == 3), 1);
        not_reset = 1'b0;
        #1;
        sb.delete();
        ref_count = 0;
        check("abort_valid", int'(oScanValid), 0);
        check("abort_busy", int'(oBusy), 0);
        check("abort_x", int'(oScanX), 0);
        check("abort_y", int'(oScanY), 0);
        check("abort_pixel", int'(oScanPixel), 0);
        check("abort_last", int'(oScanLast), 0);
        check_count("abort");
        tick();
        tick();
        not_reset = 1'b1;
        tick();
        check_count("post_abort");
        run_scan(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
